// File: rtl/fighter_pkg.sv
// fighter_pkg
// Shared definitions for the fighting-game match logic.
//   phase_t   : match sequencer phase codes (IDLE=0 .. MATCH_OVER=4)
//   winner_t  : round/match result codes; P1/P2 line up with the health
//               datapath's 01/10 player codes, 11 means draw
//   HEALTH_MAX: value the health datapath reloads on a health_reset pulse
package fighter_pkg;

    typedef enum logic [2:0] {
        PH_IDLE       = 3'd0,
        PH_READY      = 3'd1,
        PH_FIGHT      = 3'd2,
        PH_KO         = 3'd3,
        PH_MATCH_OVER = 3'd4
    } phase_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    localparam logic [8:0] HEALTH_MAX = 9'd200;

endpackage

// File: rtl/sec_tick_gen.sv
// sec_tick_gen
// Divides clk down to one-cycle "game second" ticks.
//   clk   : system clock
//   reset : synchronous active-high reset, clears the divider
//   clear : synchronous restart of the divider (used on phase changes)
//   tick  : high for one cycle once every TICKS_PER_SEC cycles; the first
//           tick after a clear/reset lands TICKS_PER_SEC cycles later
module sec_tick_gen #(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] count;

    // Free-running modulo counter; a clear restarts the second so every
    // phase gets whole seconds measured from its own entry edge.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/round_controller.sv
// round_controller
// Match-level sequencer: READY countdown -> FIGHT -> KO per round, tallies
// round wins and declares a match winner.
//   clk, reset     : system clock, synchronous active-high reset
//   start          : start button, rising edge starts a match from IDLE/MATCH_OVER
//   health_1/2     : player health from the health datapath
//   health_reset   : one-cycle pulse on the first READY cycle of each round
//   fight_en       : high only while in FIGHT
//   phase          : phase_t code
//   timer_secs     : displayed countdown
//   round_num      : current round (1-based, 0 in IDLE)
//   wins_1/2       : round wins per player, saturating at 3
//   round_winner   : last round result (winner_t)
//   match_winner   : match result (winner_t), valid in MATCH_OVER
// Build option: define ROUND_TIMER_EN to make the FIGHT timer count down and
// end the round on expiry; otherwise only a KO ends a round.
module round_controller
    import fighter_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int READY_SECS    = 3,
    parameter int ROUND_SECS    = 99,
    parameter int KO_SECS       = 2,
    parameter int WINS_TO_MATCH = 2,
    parameter int MAX_ROUNDS    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] health_1,
    input  logic [8:0] health_2,
    output logic       health_reset,
    output logic       fight_en,
    output logic [2:0] phase,
    output logic [6:0] timer_secs,
    output logic [2:0] round_num,
    output logic [1:0] wins_1,
    output logic [1:0] wins_2,
    output logic [1:0] round_winner,
    output logic [1:0] match_winner
);

    phase_t     phase_q, phase_d;
    winner_t    rw_q, rw_d, mw_q, mw_d;
    logic [6:0] timer_q, timer_d;
    logic [2:0] round_q, round_d;
    logic [1:0] wins_1_q, wins_1_d, wins_2_q, wins_2_d;
    logic       hreset_q, hreset_d;
    logic       fight_en_q, fight_en_d;
    logic       start_q;
    logic       start_rise;
    logic       tick;
    logic       tick_clear;
    winner_t    result;

    assign start_rise = start & ~start_q;
    assign tick_clear = (phase_d != phase_q);

    sec_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(tick_clear),
        .tick (tick)
    );

    // State and every output live in this one register bank so all outputs
    // are registered; reset wins over any pending start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q    <= PH_IDLE;
            rw_q       <= WIN_NONE;
            mw_q       <= WIN_NONE;
            timer_q    <= '0;
            round_q    <= '0;
            wins_1_q   <= '0;
            wins_2_q   <= '0;
            hreset_q   <= 1'b0;
            fight_en_q <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            rw_q       <= rw_d;
            mw_q       <= mw_d;
            timer_q    <= timer_d;
            round_q    <= round_d;
            wins_1_q   <= wins_1_d;
            wins_2_q   <= wins_2_d;
            hreset_q   <= hreset_d;
            fight_en_q <= fight_en_d;
            start_q    <= start;
        end
    end

    // Next-state and next-output logic. Everything holds unless a phase
    // rule changes it; health_reset is only raised on edges that enter READY.
    always_comb begin
        phase_d  = phase_q;
        rw_d     = rw_q;
        mw_d     = mw_q;
        timer_d  = timer_q;
        round_d  = round_q;
        wins_1_d = wins_1_q;
        wins_2_d = wins_2_q;
        hreset_d = 1'b0;
        result   = WIN_NONE;

        case (phase_q)
            PH_IDLE, PH_MATCH_OVER: begin
                if (start_rise) begin
                    wins_1_d = '0;
                    wins_2_d = '0;
                    rw_d     = WIN_NONE;
                    mw_d     = WIN_NONE;
                    round_d  = 3'd1;
                    timer_d  = 7'(READY_SECS);
                    hreset_d = 1'b1;
                    phase_d  = PH_READY;
                end
            end

            PH_READY: begin
                if (tick) begin
                    if (timer_q <= 7'd1) begin
                        timer_d = 7'(ROUND_SECS);
                        phase_d = PH_FIGHT;
                    end else begin
                        timer_d = timer_q - 7'd1;
                    end
                end
            end

            PH_FIGHT: begin
                // A zero health always outranks the timer in the same cycle.
                if (health_1 == 9'd0 && health_2 == 9'd0) begin
                    result = WIN_DRAW;
                end else if (health_2 == 9'd0) begin
                    result = WIN_P1;
                end else if (health_1 == 9'd0) begin
                    result = WIN_P2;
`ifdef ROUND_TIMER_EN
                end else if (tick) begin
                    if (timer_q <= 7'd1) begin
                        if (health_1 > health_2) begin
                            result = WIN_P1;
                        end else if (health_2 > health_1) begin
                            result = WIN_P2;
                        end else begin
                            result = WIN_DRAW;
                        end
                    end else begin
                        timer_d = timer_q - 7'd1;
                    end
`endif
                end

                if (result != WIN_NONE) begin
                    rw_d    = result;
                    timer_d = 7'(KO_SECS);
                    phase_d = PH_KO;
                    if (result == WIN_P1 && wins_1_q != 2'd3) begin
                        wins_1_d = wins_1_q + 2'd1;
                    end
                    if (result == WIN_P2 && wins_2_q != 2'd3) begin
                        wins_2_d = wins_2_q + 2'd1;
                    end
                end
            end

            PH_KO: begin
                if (tick) begin
                    if (timer_q <= 7'd1) begin
                        if (wins_1_q == 2'(WINS_TO_MATCH)) begin
                            mw_d    = WIN_P1;
                            phase_d = PH_MATCH_OVER;
                        end else if (wins_2_q == 2'(WINS_TO_MATCH)) begin
                            mw_d    = WIN_P2;
                            phase_d = PH_MATCH_OVER;
                        end else if (round_q == 3'(MAX_ROUNDS)) begin
                            if (wins_1_q > wins_2_q) begin
                                mw_d = WIN_P1;
                            end else if (wins_2_q > wins_1_q) begin
                                mw_d = WIN_P2;
                            end else begin
                                mw_d = WIN_DRAW;
                            end
                            phase_d = PH_MATCH_OVER;
                        end else begin
                            round_d  = round_q + 3'd1;
                            timer_d  = 7'(READY_SECS);
                            hreset_d = 1'b1;
                            phase_d  = PH_READY;
                        end
                    end else begin
                        timer_d = timer_q - 7'd1;
                    end
                end
            end

            default: begin
                phase_d = PH_IDLE;
            end
        endcase

        fight_en_d = (phase_d == PH_FIGHT);
    end

    assign phase        = phase_q;
    assign round_winner = rw_q;
    assign match_winner = mw_q;
    assign timer_secs   = timer_q;
    assign round_num    = round_q;
    assign wins_1       = wins_1_q;
    assign wins_2       = wins_2_q;
    assign health_reset = hreset_q;
    assign fight_en     = fight_en_q;

endmodule

// File: doc/round_controller.md
# round_controller

Match-level sequencer for the fighting game. It sits above the health-management datapath, which holds health_1/health_2 and decrements them on hits. It drives that datapath's reset and gates attacks through fight_en. Each round runs READY countdown → FIGHT → KO, the block tallies round wins, and it declares a match winner after WINS_TO_MATCH round wins or MAX_ROUNDS rounds.

## Interface
Parameters:
- TICKS_PER_SEC, 100_000_000: clk cycles per game second.
- READY_SECS, 3: pre-fight countdown length in seconds.
- ROUND_SECS, 99: fight timer start value in seconds (≤127).
- KO_SECS, 2: post-round display hold in seconds.
- WINS_TO_MATCH, 2: round wins needed to take the match (1..3).
- MAX_ROUNDS, 5: hard round cap (1..7).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  start button; acts on its rising edge only.
- health_1  in  9  player 1 health from the health datapath.
- health_2  in  9  player 2 health from the health datapath.
- health_reset  out  1  one-cycle pulse that reloads health to 200.
- fight_en  out  1  high only in FIGHT; gates the attack inputs.
- phase  out  3  FSM state code.
- timer_secs  out  7  countdown currently displayed.
- round_num  out  3  current round, 1-based; 0 in IDLE.
- wins_1  out  2  player 1 round wins.
- wins_2  out  2  player 2 round wins.
- round_winner  out  2  last round result.
- match_winner  out  2  match result; valid in MATCH_OVER.

## Operation
- Winner codes: 00 none, 01 P1, 10 P2, 11 draw.
- Phase codes: IDLE=0, READY=1, FIGHT=2, KO=3, MATCH_OVER=4.
- Reset: phase IDLE. All outputs 0, including health_reset and fight_en. The tick counter and start edge register are cleared.
- IDLE or MATCH_OVER, on a start rising edge:
  - wins cleared, round_winner and match_winner set to 00.
  - round_num=1, timer_secs=READY_SECS, health_reset pulses, phase goes to READY.
- READY: timer_secs decrements on each second tick.
  - On the tick where timer_secs==1 → FIGHT, timer_secs=ROUND_SECS.
- FIGHT: fight_en=1. Each cycle, checks in priority order:
  - health_1==0 and health_2==0 → draw.
  - health_2==0 → P1.
  - health_1==0 → P2.
  - Timer expiry (see Configuration) → higher health wins; equal health → draw.
  - Any result goes to KO.
- KO entry:
  - round_winner latched.
  - The winner's wins counter increments, saturating at 3. A draw increments neither counter.
  - timer_secs=KO_SECS. Counts down as in READY.
- KO expiry, first match applies:
  - wins_1==WINS_TO_MATCH → MATCH_OVER, match_winner=01.
  - wins_2==WINS_TO_MATCH → MATCH_OVER, match_winner=10.
  - round_num==MAX_ROUNDS → MATCH_OVER; more wins takes it, equal wins gives 11.
  - Otherwise round_num+1, health_reset pulse, timer_secs=READY_SECS, READY.
- MATCH_OVER: all outputs are held until the next start edge. start held high does not retrigger.
- start edges in READY, FIGHT or KO are ignored.

## Timing
- All outputs are registered.
- health_reset is high exactly one cycle: the first cycle phase reads READY.
- Second tick:
  - The counter clears on every phase change.
  - First tick occurs TICKS_PER_SEC cycles after phase entry, then every TICKS_PER_SEC cycles.
- KO latency: phase reads KO on the first edge after a cycle in which FIGHT sees a zero health. fight_en drops on that same edge.
- Timer-expiry latency: the fight-timer tick that takes timer_secs from 1 to 0 moves the FSM to KO on the same edge. timer_secs reads KO_SECS, not 0.
- A KO and the final timer tick in the same cycle resolve as a KO.
- Synchronous reset in any phase takes effect on the next edge and overrides start.

## Configuration
- ROUND_TIMER_EN defined: the FIGHT timer counts down and expiry ends the round.
- Undefined:
  - timer_secs holds ROUND_SECS throughout FIGHT and no timeout exists; only KO ends a round.
  - READY and KO countdowns are unaffected.

## Structure
- Shared package fighter_pkg holds:
  - the phase encodings;
  - the winner codes, aligned with the health datapath's 01/10 state codes;
  - the HEALTH_MAX=200 constant.
- Sub-module sec_tick_gen: a TICKS_PER_SEC divider with a synchronous clear input and a one-cycle tick output.

## Test plan
All scenarios use TICKS_PER_SEC=4, READY_SECS=2, ROUND_SECS=3, KO_SECS=1.
- Start edge from IDLE → health_reset 1 for one cycle, phase=1, timer 2. phase=2 and fight_en=1 after 8 cycles.
- In FIGHT, drive health_2=0 → next edge phase=3, round_winner=01, wins_1=1, fight_en=0.
- P1 wins two rounds → after the second KO hold, phase=4, match_winner=01. start held high causes no restart; a new rising edge gives round_num=1, wins 0.
- ROUND_TIMER_EN defined, health_1=150 and health_2=120 constant → KO at FIGHT entry+12 cycles, round_winner=01. Equal health gives 11.
- health_1 and health_2 both 0 in the same cycle → round_winner=11, wins unchanged. Five draws with MAX_ROUNDS=5 → match_winner=11.
- reset asserted mid-FIGHT → next edge phase=0, all outputs 0, fight_en=0.
